// File: rtl/sound_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sound_frame_sequencer
// Brief    : 512 Hz frame sequencer, register-write snooping, length counters
//            and channel-active / power status for the four sound channels.
// Revision : 1.0
// ============================================================================
module sound_frame_sequencer #(
    parameter int CLK_DIV = 24000
) (
    input  logic       ac97_bitclk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       len_tick,
    output logic       sweep_tick,
    output logic       env_tick,
    output logic [3:0] ch_trigger,
    output logic [3:0] ch_active,
    output logic [7:0] nr52_status
);
    localparam int                 c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(CLK_DIV - 1);

    logic [c_DIV_W-1:0] r_div;
    logic [2:0]         r_step;
    logic               r_power;
    logic [3:0][8:0]    r_len;
    logic [3:0]         r_len_en;
    logic [3:0]         r_dac;
    logic [3:0]         r_active;
    logic               r_len_tick;
    logic               r_sweep_tick;
    logic               r_env_tick;
    logic [3:0]         r_trig;

    logic               w_wrap;
    logic               w_len_evt;
    logic               w_sweep_evt;
    logic               w_env_evt;
    logic               w_nr52_wr;
    logic [3:0]         w_hit_len;
    logic [3:0]         w_hit_dac;
    logic [3:0]         w_hit_ctl;
    logic [3:0][8:0]    w_len_nxt;
    logic [3:0]         w_len_en_nxt;
    logic [3:0]         w_dac_nxt;
    logic [3:0]         w_act_nxt;
    logic [3:0]         w_trig_nxt;

    always_comb begin
        w_wrap      = (r_div == c_DIV_MAX);
        w_len_evt   = r_power && w_wrap && !r_step[0];
        w_sweep_evt = r_power && w_wrap && (r_step[1:0] == 2'b10);
        w_env_evt   = r_power && w_wrap && (r_step == 3'd7);
        w_nr52_wr   = wr_en && (wr_addr == 8'h26);

        w_hit_len = '0;
        w_hit_dac = '0;
        w_hit_ctl = '0;
        if (wr_en && r_power) begin
            case (wr_addr)
                8'h11: w_hit_len[0] = 1'b1;
                8'h16: w_hit_len[1] = 1'b1;
                8'h1B: w_hit_len[2] = 1'b1;
                8'h20: w_hit_len[3] = 1'b1;
                8'h12: w_hit_dac[0] = 1'b1;
                8'h17: w_hit_dac[1] = 1'b1;
                8'h1A: w_hit_dac[2] = 1'b1;
                8'h21: w_hit_dac[3] = 1'b1;
                8'h14: w_hit_ctl[0] = 1'b1;
                8'h19: w_hit_ctl[1] = 1'b1;
                8'h1E: w_hit_ctl[2] = 1'b1;
                8'h23: w_hit_ctl[3] = 1'b1;
                default: ;
            endcase
        end

        // Priority within one edge: length clock, then register writes, so a
        // write or trigger reload overrides the decrement.
        for (int n = 0; n < 4; n++) begin
            w_len_nxt[n]    = r_len[n];
            w_len_en_nxt[n] = r_len_en[n];
            w_dac_nxt[n]    = r_dac[n];
            w_act_nxt[n]    = r_active[n];
            w_trig_nxt[n]   = 1'b0;

            if (w_len_evt && r_len_en[n] && (r_len[n] != 9'd0)) begin
                w_len_nxt[n] = r_len[n] - 9'd1;
                if (r_len[n] == 9'd1)
                    w_act_nxt[n] = 1'b0;
            end

            if (w_hit_len[n])
                w_len_nxt[n] = (n == 2) ? (9'd256 - {1'b0, wr_data})
                                        : (9'd64 - {3'b000, wr_data[5:0]});

            if (w_hit_dac[n]) begin
                w_dac_nxt[n] = (n == 2) ? wr_data[7] : (wr_data[7:3] != 5'd0);
                if (!w_dac_nxt[n])
                    w_act_nxt[n] = 1'b0;
            end

            if (w_hit_ctl[n]) begin
                w_len_en_nxt[n] = wr_data[6];
                if (wr_data[7]) begin
                    w_trig_nxt[n] = 1'b1;
                    w_act_nxt[n]  = r_dac[n];
                    if (w_len_nxt[n] == 9'd0)
                        w_len_nxt[n] = (n == 2) ? 9'd256 : 9'd64;
                end
            end
        end
    end

    always_ff @(posedge ac97_bitclk) begin
        if (reset) begin
            r_power      <= 1'b1;
            r_div        <= '0;
            r_step       <= '0;
            r_len        <= '0;
            r_len_en     <= '0;
            r_dac        <= '0;
            r_active     <= '0;
            r_len_tick   <= 1'b0;
            r_sweep_tick <= 1'b0;
            r_env_tick   <= 1'b0;
            r_trig       <= '0;
        end else if (w_nr52_wr && !wr_data[7]) begin
            r_power      <= 1'b0;
            r_div        <= '0;
            r_step       <= '0;
            r_len        <= '0;
            r_len_en     <= '0;
            r_dac        <= '0;
            r_active     <= '0;
            r_len_tick   <= 1'b0;
            r_sweep_tick <= 1'b0;
            r_env_tick   <= 1'b0;
            r_trig       <= '0;
        end else begin
            if (w_nr52_wr)
                r_power <= 1'b1;
            if (r_power) begin
                r_div <= w_wrap ? '0 : r_div + 1'b1;
                if (w_wrap)
                    r_step <= r_step + 3'd1;
            end
            r_len_tick   <= w_len_evt;
            r_sweep_tick <= w_sweep_evt;
            r_env_tick   <= w_env_evt;
            r_trig       <= w_trig_nxt;
            r_len        <= w_len_nxt;
            r_len_en     <= w_len_en_nxt;
            r_dac        <= w_dac_nxt;
            r_active     <= w_act_nxt;
        end
    end

    assign len_tick    = r_len_tick;
    assign sweep_tick  = r_sweep_tick;
    assign env_tick    = r_env_tick;
    assign ch_trigger  = r_trig;
    assign ch_active   = r_active;
    assign nr52_status = {r_power, 3'b000, r_active};

endmodule
`default_nettype wire
